// File: rtl/serializer_tx_lane.sv
// serializer_tx_lane: byte-to-serial TX lane, MSB first, COM alignment burst after reset,
// IDLE fill when no data is offered and optional periodic COM re-insertion.
`default_nettype none

module serializer_tx_lane #(
  parameter int          BC_COUNT   = 4,
  parameter logic [7:0]  COM_SYM    = 8'hBC,
  parameter logic [7:0]  IDLE_SYM   = 8'h7C,
  parameter int          COM_PERIOD = 0
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       serial_out,
  output logic       byte_strobe,
  output logic       active_out
);

  typedef enum logic [0:0] {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [3:0] COM_LAST  = 4'(BC_COUNT - 1);
  localparam logic [7:0] PERIOD    = 8'(COM_PERIOD);
  localparam bit         PERIOD_EN = (COM_PERIOD != 0);

  state_t     state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [7:0] next_sym;
  logic [7:0] data_cnt, data_cnt_nxt;
  logic [3:0] com_cnt, com_cnt_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       active_q, active_nxt;
  logic       load;
  logic       force_com;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= SYNC;
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd7;
      com_cnt   <= 4'd0;
      data_cnt  <= 8'd0;
      active_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      data_cnt  <= data_cnt_nxt;
      active_q  <= active_nxt;
    end
  end

  always_comb begin
    load         = (bit_cnt == 3'd7);
    force_com    = PERIOD_EN && (state == ACTIVE) && (data_cnt == PERIOD);
    state_nxt    = state;
    com_cnt_nxt  = com_cnt;
    data_cnt_nxt = data_cnt;
    active_nxt   = active_q;
    next_sym     = IDLE_SYM;
    ready_out    = 1'b0;

    case (state)
      SYNC: begin
        next_sym = COM_SYM;
        if (load) begin
          if (com_cnt == COM_LAST) begin
            state_nxt   = ACTIVE;
            com_cnt_nxt = 4'd0;
          end else begin
            com_cnt_nxt = com_cnt + 4'd1;
          end
        end
      end
      ACTIVE: begin
        // Ready depends only on registered state so upstream never sees a valid->ready loop.
        ready_out = load && !force_com;
        if (force_com) begin
          next_sym = COM_SYM;
          if (load) data_cnt_nxt = 8'd0;
        end else if (valid_in) begin
          next_sym = data_in;
          if (load && PERIOD_EN) data_cnt_nxt = data_cnt + 8'd1;
        end
        if (load) active_nxt = 1'b1;
      end
      default: state_nxt = SYNC;
    endcase

    shift_nxt   = load ? next_sym : {shift_reg[6:0], 1'b0};
    bit_cnt_nxt = load ? 3'd0 : bit_cnt + 3'd1;
  end

  // Reset parks bit_cnt at 7, so the strobe stays low until the first symbol is loaded.
  assign serial_out  = shift_reg[7];
  assign byte_strobe = (bit_cnt == 3'd0);
  assign active_out  = active_q;

endmodule

`default_nettype wire

// File: tb/tb_serializer_tx_lane.sv
// Scoreboard bench: stimulus pushes expected symbols, per-lane monitors rebuild and compare them.
`default_nettype none

module tb_serializer_tx_lane;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, valid_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       ready_a, ser_a, strb_a, act_a;
  logic       rst_b = 1'b1, valid_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       ready_b, ser_b, strb_b, act_b;

  int errors = 0;
  int checks = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  serializer_tx_lane dut_a (
    .clk_32f(clk), .reset(rst_a), .data_in(data_a), .valid_in(valid_a),
    .ready_out(ready_a), .serial_out(ser_a), .byte_strobe(strb_a), .active_out(act_a)
  );

  serializer_tx_lane #(.BC_COUNT(1), .COM_PERIOD(2)) dut_b (
    .clk_32f(clk), .reset(rst_b), .data_in(data_b), .valid_in(valid_b),
    .ready_out(ready_b), .serial_out(ser_b), .byte_strobe(strb_b), .active_out(act_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte until the handshake edge; waits = cycles spent before ready was seen.
  task automatic send(input bit sel, input logic [7:0] d, output int waits);
    waits = 0;
    if (!sel) begin data_a = d; valid_a = 1'b1; end
    else      begin data_b = d; valid_b = 1'b1; end
    while (((sel ? ready_b : ready_a) == 1'b0) && waits < 24) begin
      step();
      waits++;
    end
    if (waits >= 24) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted (waited %0d)", d, waits);
    end else if (!sel) qa.push_back(d);
    else qb.push_back(d);
    step();
  endtask

  // Lane A monitor
  int         cnt_a = 0;
  logic [7:0] sh_a;
  always @(negedge clk) begin
    if (rst_a) cnt_a = 0;
    else begin
      if (strb_a) begin
        if (cnt_a != 0) chk("lane_a_short_symbol", 32'(cnt_a), 32'd0);
        sh_a = {7'd0, ser_a}; cnt_a = 1;
      end else if (cnt_a > 0) begin
        sh_a = {sh_a[6:0], ser_a}; cnt_a++;
      end
      if (cnt_a == 8) begin
        cnt_a = 0;
        if (qa.size() != 0) chk("lane_a_symbol", 32'(sh_a), 32'(qa.pop_front()));
        else if (sh_a != 8'h7C) chk("lane_a_unexpected", 32'(sh_a), 32'h7C);
      end
    end
  end

  // Lane B monitor
  int         cnt_b = 0;
  logic [7:0] sh_b;
  always @(negedge clk) begin
    if (rst_b) cnt_b = 0;
    else begin
      if (strb_b) begin
        if (cnt_b != 0) chk("lane_b_short_symbol", 32'(cnt_b), 32'd0);
        sh_b = {7'd0, ser_b}; cnt_b = 1;
      end else if (cnt_b > 0) begin
        sh_b = {sh_b[6:0], ser_b}; cnt_b++;
      end
      if (cnt_b == 8) begin
        cnt_b = 0;
        if (qb.size() != 0) chk("lane_b_symbol", 32'(sh_b), 32'(qb.pop_front()));
        else if (sh_b != 8'h7C) chk("lane_b_unexpected", 32'(sh_b), 32'h7C);
      end
    end
  end

  initial begin
    int w;
    int c;

    // Reset state and sync burst followed by idle
    repeat (3) step();
    chk("reset_serial", 32'(ser_a), 32'd0);
    chk("reset_ready", 32'(ready_a), 32'd0);
    chk("reset_strobe", 32'(strb_a), 32'd0);
    chk("reset_active", 32'(act_a), 32'd0);
    repeat (4) qa.push_back(8'hBC);
    repeat (2) qa.push_back(8'h7C);
    rst_a = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      step();
      chk("sync_strobe", 32'(strb_a), 32'((i % 8) == 1));
      chk("sync_ready", 32'(ready_a), 32'((i >= 32) && ((i % 8) == 0)));
      if (i == 32) chk("active_before_5th", 32'(act_a), 32'd0);
      if (i == 33) chk("active_at_5th", 32'(act_a), 32'd1);
    end

    // Back-to-back stream, no idle between symbols
    send(1'b0, 8'hFF, w);
    chk("stream_wait_ff", 32'(w), 32'd0);
    send(1'b0, 8'hF0, w);
    chk("stream_wait_f0", 32'(w), 32'd7);
    send(1'b0, 8'h0F, w);
    chk("stream_wait_0f", 32'(w), 32'd7);
    valid_a = 1'b0;

    // Valid raised mid-symbol
    repeat (3) step();
    send(1'b0, 8'hA5, w);
    chk("midsym_wait", 32'(w), 32'd4);
    valid_a = 1'b0;

    // Reset during the 4th bit of a data byte
    send(1'b0, 8'h5A, w);
    valid_a = 1'b0;
    repeat (3) step();
    rst_a = 1'b1;
    qa.delete();
    step();
    chk("midreset_serial", 32'(ser_a), 32'd0);
    chk("midreset_active", 32'(act_a), 32'd0);
    chk("midreset_ready", 32'(ready_a), 32'd0);
    repeat (4) qa.push_back(8'hBC);
    rst_a = 1'b0;
    c = 0;
    while (!ready_a && c < 40) begin
      step();
      c++;
    end
    chk("resync_first_ready", 32'(c), 32'd32);
    send(1'b0, 8'h3C, w);
    chk("resync_wait", 32'(w), 32'd0);
    valid_a = 1'b0;

    // Lane B: single COM sync, then periodic COM after every 2 data symbols
    qb.push_back(8'hBC);
    rst_b = 1'b0;
    c = 0;
    while (!ready_b && c < 40) begin
      step();
      c++;
    end
    chk("bc1_first_ready", 32'(c), 32'd8);
    send(1'b1, 8'h11, w);
    chk("period_wait_11", 32'(w), 32'd0);
    send(1'b1, 8'h22, w);
    chk("period_wait_22", 32'(w), 32'd7);
    qb.push_back(8'hBC);
    send(1'b1, 8'h33, w);
    chk("period_wait_33", 32'(w), 32'd15);
    valid_b = 1'b0;
    chk("bc1_active", 32'(act_b), 32'd1);

    repeat (24) step();
    chk("lane_a_drained", 32'(qa.size()), 32'd0);
    chk("lane_b_drained", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
